// File: rtl/hazard_pipe.sv
// Hazard tracker for an in-order pipeline: per-stage {valid, a3, tnew}, stall decision and forwarding selects.
// Optional stall statistics counter enabled by defining HAZARD_PIPE_STATS_EN.
module hazard_pipe #(
  parameter int DEPTH = 3,
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int TW    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_valid,
  input  logic [AW-1:0]       d_a3,
  input  logic [TW-1:0]       d_tnew,
  input  logic [AW-1:0]       d_rs,
  input  logic [AW-1:0]       d_rt,
  input  logic [TW-1:0]       d_tuse_rs,
  input  logic [TW-1:0]       d_tuse_rt,
  input  logic                flush,
  input  logic [DEPTH*DW-1:0] stage_res,
  output logic                stall,
  output logic [3:0]          fwd_rs_sel,
  output logic [3:0]          fwd_rt_sel,
  output logic [DW-1:0]       fwd_rs_data,
  output logic [DW-1:0]       fwd_rt_data,
  output logic                fwd_rs_pend,
  output logic                fwd_rt_pend,
  output logic [DEPTH-1:0]    stage_valid,
  output logic [DEPTH*AW-1:0] stage_a3,
  output logic [31:0]         stall_cnt
);

  typedef struct packed {
    logic          stall;
    logic [3:0]    sel;
    logic          pend;
    logic [DW-1:0] data;
  } src_res_t;

  // Index k holds stage k+1 (E, M, W, ...).
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    a3_q   [DEPTH];
  logic [TW-1:0]    tnew_q [DEPTH];

  src_res_t rs_res, rt_res;

  // NOTE: the small tracking array is fully reset; a stale a3/tnew in a bubble would otherwise be harmless,
  // but clearing it keeps stage_a3 deterministic and matches flush behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a3_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a3_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      if (stall) begin
        valid_q[0] <= 1'b0;
        a3_q[0]    <= '0;
        tnew_q[0]  <= '0;
      end else begin
        valid_q[0] <= d_valid;
        a3_q[0]    <= d_a3;
        tnew_q[0]  <= d_tnew;
      end
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        a3_q[k]    <= a3_q[k-1];
        tnew_q[k]  <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
    end
  end

  // Only the youngest (lowest-numbered) matching producer decides the outcome for a source.
  function automatic src_res_t resolve(input logic [AW-1:0] src, input logic [TW-1:0] tuse);
    src_res_t r;
    logic     found;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && valid_q[k] && (a3_q[k] != '0) && (a3_q[k] == src)) begin
        found = 1'b1;
        if (tnew_q[k] > tuse) begin
          r.stall = 1'b1;
        end else if (tnew_q[k] == '0) begin
          r.sel  = 4'(k + 1);
          r.data = stage_res[k*DW +: DW];
        end else begin
          r.pend = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    rs_res      = resolve(d_rs, d_tuse_rs);
    rt_res      = resolve(d_rt, d_tuse_rt);
    stall       = d_valid & (rs_res.stall | rt_res.stall);
    fwd_rs_sel  = rs_res.sel;
    fwd_rs_data = rs_res.data;
    fwd_rs_pend = rs_res.pend;
    fwd_rt_sel  = rt_res.sel;
    fwd_rt_data = rt_res.data;
    fwd_rt_pend = rt_res.pend;
  end

  assign stage_valid = valid_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_a3
    assign stage_a3[g*AW +: AW] = a3_q[g];
  end

`ifdef HAZARD_PIPE_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe.sv
// Directed bench for hazard_pipe: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Define HAZARD_PIPE_STATS_EN for both files to also check the stall counter.
module tb_hazard_pipe;

`ifdef HAZARD_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_a3, d_rs, d_rt;
  logic [1:0]  d_tnew, d_tuse_rs, d_tuse_rt;
  logic        flush;
  logic [95:0] stage_res;
  logic        stall, fwd_rs_pend, fwd_rt_pend;
  logic [3:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] fwd_rs_data, fwd_rt_data, stall_cnt;
  logic [2:0]  stage_valid;
  logic [14:0] stage_a3;

  hazard_pipe dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .flush(flush), .stage_res(stage_res), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .fwd_rs_pend(fwd_rs_pend), .fwd_rt_pend(fwd_rt_pend),
    .stage_valid(stage_valid), .stage_a3(stage_a3), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {stall, rs_sel, rs_pend, rs_data, rt_sel, rt_pend, rt_data, stage_valid, stage_a3, stall_cnt}
  typedef logic [124:0] obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic logic [31:0] ec(input logic [31:0] n);
    return STATS ? n : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a3, input logic [1:0] tn,
                       input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut);
    d_valid = v; d_a3 = a3; d_tnew = tn;
    d_rs = rs; d_tuse_rs = tur; d_rt = rt; d_tuse_rt = tut;
  endtask

  task automatic expect_out(input string nm, input logic st,
                            input logic [3:0] ss, input logic sp, input logic [31:0] sd,
                            input logic [3:0] ts, input logic tp, input logic [31:0] td,
                            input logic [2:0] sv, input logic [14:0] sa, input logic [31:0] c);
    exp_q.push_back({st, ss, sp, sd, ts, tp, td, sv, sa, c});
    name_q.push_back(nm);
  endtask

  // Monitor: the DUT is combinational from state, so every scheduled sample is a presented output.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall, fwd_rs_sel, fwd_rs_pend, fwd_rs_data, fwd_rt_sel, fwd_rt_pend, fwd_rt_data,
            stage_valid, stage_a3, stall_cnt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", nm, a, e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b1, 5'd8, 2'd2, 5'd8, 2'd0, 5'd8, 2'd0);
    stage_res = {32'h0000_00C3, 32'h0000_00B2, 32'h0000_00A1};
    #2;
    expect_out("reset_state", 0, 0, 0, 0, 0, 0, 0, 3'b000, 15'h0000, 0);
    #10;
    reset = 1'b1;
    drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);

    // load-use: producer with tnew=2 against tuse=1 stalls once, then pends
    tick(); drive(1, 5'd8, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    expect_out("idle_first", 0, 0, 0, 0, 0, 0, 0, 3'b000, 15'h0000, 0);
    tick(); drive(1, 5'd9, 2'd1, 5'd8, 2'd1, 5'd0, 2'd0);
    expect_out("load_use_stall", 1, 0, 0, 0, 0, 0, 0, 3'b001, 15'h0008, 0);
    tick();
    expect_out("load_use_pend", 0, 0, 1, 0, 0, 0, 0, 3'b010, 15'h0100, ec(1));
    tick(); drive(1, 5'd0, 2'd0, 5'd8, 2'd0, 5'd9, 2'd0);
    expect_out("fwd_w_and_stall", 1, 4'd3, 0, 32'h0000_00C3, 0, 0, 0, 3'b101, 15'h2009, ec(1));
    tick();
    expect_out("fwd_m_after_stall", 0, 0, 0, 0, 4'd2, 0, 32'h0000_00B2, 3'b010, 15'h0120, ec(2));

    // register 0 never matches; stall request gated by d_valid
    tick(); drive(1, 5'd3, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    expect_out("zero_reg_no_match", 0, 0, 0, 0, 0, 0, 0, 3'b101, 15'h2400, ec(2));
    tick(); drive(0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd3, 2'd0);
    expect_out("stall_gated_dvalid", 0, 0, 0, 0, 0, 0, 0, 3'b011, 15'h0003, ec(2));

    // ALU forward from stage 2
    tick(); drive(1, 5'd5, 2'd0, 5'd0, 2'd0, 5'd3, 2'd0);
    stage_res = {32'h0000_00C3, 32'h0000_1234, 32'h0000_00A1};
    expect_out("alu_fwd_rt", 0, 0, 0, 0, 4'd2, 0, 32'h0000_1234, 3'b110, 15'h0060, ec(2));

    // youngest producer wins
    tick(); drive(1, 5'd7, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    expect_out("fill_a", 0, 0, 0, 0, 0, 0, 0, 3'b101, 15'h0C05, ec(2));
    tick(); drive(1, 5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    expect_out("fill_b", 0, 0, 0, 0, 0, 0, 0, 3'b011, 15'h00A7, ec(2));
    tick(); drive(1, 5'd6, 2'd3, 5'd5, 2'd0, 5'd7, 2'd0);
    stage_res = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
    expect_out("youngest_wins", 0, 4'd1, 0, 32'h5555_0001, 4'd2, 0, 32'h5555_0002, 3'b111, 15'h14E5, ec(2));

    // flush during a multi-cycle stall
    tick(); drive(1, 5'd0, 2'd0, 5'd6, 2'd0, 5'd0, 2'd0);
    expect_out("stall_tnew3", 1, 0, 0, 0, 0, 0, 0, 3'b111, 15'h1CA6, ec(2));
    tick(); flush = 1'b1;
    expect_out("stall_tnew2_flush", 1, 0, 0, 0, 0, 0, 0, 3'b110, 15'h14C0, ec(3));
    tick(); flush = 1'b0;
    expect_out("after_flush", 0, 0, 0, 0, 0, 0, 0, 3'b000, 15'h0000, ec(3));

    // reset asserted mid-stall clears everything at once
    tick(); drive(1, 5'd4, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0);
    expect_out("pre_stall", 0, 0, 0, 0, 0, 0, 0, 3'b001, 15'h0000, ec(3));
    tick(); drive(1, 5'd0, 2'd0, 5'd4, 2'd1, 5'd0, 2'd0);
    expect_out("stall_before_reset", 1, 0, 0, 0, 0, 0, 0, 3'b011, 15'h0004, ec(3));
    tick(); reset = 1'b0; drive(1, 5'd8, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    #1;
    expect_out("reset_mid_stall", 0, 0, 0, 0, 0, 0, 0, 3'b000, 15'h0000, 0);
    @(negedge clk); #1; reset = 1'b1;

    // first edge after reset loads normally; tnew==tuse pends
    tick(); drive(1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 2'd2);
    expect_out("resume_pend_eq", 0, 0, 0, 0, 0, 1, 0, 3'b001, 15'h0008, 0);
    tick(); drive(1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 2'd0);
`ifdef HAZARD_PIPE_STATS_EN
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
`endif
    expect_out("stall_cnt_preload", 1, 0, 0, 0, 0, 0, 0, 3'b011, 15'h0100, ec(32'hFFFF_FFFF));
    tick();
    expect_out("stall_cnt_saturate", 0, 0, 0, 0, 4'd3, 0, 32'h5555_0003, 3'b110, 15'h2000, ec(32'hFFFF_FFFF));

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
